spi_reg_responder: RTL
======================

Name: spi_reg_responder

Overview:
- SPI mode-0 target that emulates a byte-addressed register file, i.e. the peripheral end of the SoC's SPI master link.
- The first byte of each transaction is a command: bits[7:3] register address, bit[1] write=1/read=0, other bits ignored.
- Following bytes write or read registers, auto-incrementing the address.
- A local port gives fabric logic single-cycle access to the same registers.

Parameters:
- SYNC_STAGES, 2, flops in each SPI input synchronizer (min 2).
- AUTO_INC, 1, 1 = address increments after each data byte (31 wraps to 0); 0 = address held.
- STATUS_ADDR, 5'd0, register shifted out on MISO during the command byte.

Ports:
- clk_clk  in  1  system clock; must be >= 8x SCLK frequency.
- reset_reset_n  in  1  asynchronous active-low reset.
- spi_SCLK  in  1  SPI clock from master, asynchronous.
- spi_SS_n  in  1  chip select from master, active low, asynchronous.
- spi_MOSI  in  1  serial data from master.
- spi_MISO  out  1  serial data to master.
- reg_addr  in  5  local register address.
- reg_wr  in  1  local write strobe.
- reg_wdata  in  8  local write data.
- reg_rdata  out  8  registered read of regs[reg_addr], 1-cycle latency.
- busy  out  1  synchronized SS_n low (transaction in progress).

Behaviour:
- Reset state:
  - all 32 registers 0x00; spi_MISO 0; reg_rdata 0x00; busy 0; FSM in IDLE; bit counter 0.
  - Reset asserted mid-transaction aborts it; no partial write survives.
- Synchronizers and edge detection:
  - SCLK, SS_n and MOSI each pass through SYNC_STAGES flops.
  - Edge detect on the synchronized SCLK gives sclk_rise and sclk_fall; the same is done for SS_n.
  - MOSI is sampled on sclk_rise, MSB first.
- FSM states and transitions:
  - IDLE -> CMD on SS_n fall. At that point load tx_shift with regs[STATUS_ADDR], clear the bit counter, and drive MISO = tx_shift[7].
  - CMD: on the 8th sclk_rise, latch addr = rx[7:3] and wr = rx[1], then go to DATA.
    - For a read, load tx_shift with regs[addr] on that same cycle.
  - DATA, write: on each 8th sclk_rise, regs[addr] <= rx_byte one cycle later, then addr advances per AUTO_INC.
  - DATA, read: on each 8th sclk_rise, addr advances per AUTO_INC and tx_shift reloads with regs[new addr].
  - Any state -> IDLE on SS_n rise.
- MISO timing:
  - MISO updates only on sclk_fall, shifting out the next bit.
  - The MSB of each byte is presented on the first sclk_fall after the previous byte completes (mode 0).
  - MISO is forced to 0 while SS_n is high.
  - During write transactions, data bytes return regs[STATUS_ADDR] on MISO.
- Boundary conditions:
  - SS_n rising mid-byte (1..7 bits received) discards the partial byte: no write, no address advance.
  - A transaction of command byte only is legal and has no effect.
  - Address wrap: 31 -> 0 when AUTO_INC=1.
- Local port vs SPI:
  - If a local write and an SPI write hit the same register in the same cycle, the SPI write wins and the local write is dropped.
  - Local writes to other addresses proceed in parallel.
  - A local write to the address currently loaded in tx_shift does not change the byte already being shifted.
- Latency: register update lands SYNC_STAGES+2 clk_clk cycles after the physical 8th SCLK rising edge.

Optional Feature:
- SPI_REG_IRQ_EN defined:
  - adds output irq (1 bit) and input irq_ack (1 bit).
  - irq sets one cycle after any completed SPI write byte and stays high until irq_ack is pulsed.
  - A set and an ack in the same cycle leave irq = 1.
  - Reset value of irq is 0.
- SPI_REG_IRQ_EN undefined: the irq and irq_ack ports and their logic are absent; everything else is identical.

Decomposition:
- Package spi_reg_pkg holds:
  - localparams REG_ADDR_W=5, REG_DATA_W=8, NUM_REGS=32;
  - typedef state_t {IDLE, CMD, DATA};
  - command-field bit positions CMD_ADDR_MSB=7, CMD_ADDR_LSB=3, CMD_WR_BIT=1.
- One sub-module, spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs, instantiated for SCLK and SS_n. MOSI uses the synchronizer only.

Test Plan:
- SPI write: SS_n low, send 0x2A (addr 5, wr) then 0x11, 0x22 -> regs[5]=0x11, regs[6]=0x22; reg_addr=6 gives reg_rdata 0x22 next cycle.
- SPI read: preload regs[3]=0xA5, regs[4]=0x3C locally; send 0x18 then two dummy bytes -> MISO returns regs[0], then 0xA5, then 0x3C.
- Wrap: send 0xFA (addr 31, wr) then 0x01, 0x02 -> regs[31]=0x01, regs[0]=0x02.
- Abort: send 0x2A then 4 bits and raise SS_n -> regs[5] unchanged; the next transaction decodes its command normally.
- Collision: local write regs[5]=0x77 in the same cycle as the SPI write of 0x11 to regs[5] -> regs[5]=0x11. With SPI_REG_IRQ_EN defined, irq=1 until irq_ack.
- Async reset asserted mid-read -> MISO=0, busy=0, all registers 0x00 immediately.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared sizes, FSM state type and command-byte field positions for spi_reg_responder.
package spi_reg_pkg;
   localparam int REG_ADDR_W   = 5;
   localparam int REG_DATA_W   = 8;
   localparam int NUM_REGS     = 32;
   localparam int CMD_ADDR_MSB = 7;
   localparam int CMD_ADDR_LSB = 3;
   localparam int CMD_WR_BIT   = 1;
   typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer for an asynchronous input with rise/fall pulse outputs.
module spi_sync_edge #(
   parameter int   STAGES   = 2,
   parameter logic IDLE_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_rise,
   output logic o_fall
);
   logic [STAGES-1:0] r_sync;
   logic              r_prev;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_sync <= {STAGES{IDLE_VAL}};
         r_prev <= IDLE_VAL;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
         r_prev <= r_sync[STAGES-1];
      end
   assign o_rise = r_sync[STAGES-1] & ~r_prev;
   assign o_fall = ~r_sync[STAGES-1] & r_prev;
endmodule

// File: rtl/spi_reg_responder.sv
// spi_reg_responder: SPI mode-0 target exposing a 32x8 register file, plus a local fabric port.
// Define SPI_REG_IRQ_EN to add the irq/irq_ack write-notification interrupt.
module spi_reg_responder
   import spi_reg_pkg::*;
#(
   parameter int                    SYNC_STAGES = 2,
   parameter logic                  AUTO_INC    = 1'b1,
   parameter logic [REG_ADDR_W-1:0] STATUS_ADDR = 5'd0
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset_n,
   input  logic                  spi_SCLK,
   input  logic                  spi_SS_n,
   input  logic                  spi_MOSI,
   output logic                  spi_MISO,
   input  logic [REG_ADDR_W-1:0] reg_addr,
   input  logic                  reg_wr,
   input  logic [REG_DATA_W-1:0] reg_wdata,
   output logic [REG_DATA_W-1:0] reg_rdata,
   output logic                  busy
`ifdef SPI_REG_IRQ_EN
   ,
   output logic                  irq,
   input  logic                  irq_ack
`endif
);
   logic [NUM_REGS-1:0][REG_DATA_W-1:0] r_regs;
   logic [REG_DATA_W-1:0]               r_rdata, r_rx, r_tx;
   logic [SYNC_STAGES-1:0]              r_mosi_sync;
   logic [REG_ADDR_W-1:0]               r_addr;
   logic [2:0]                          r_bit_cnt;
   logic                                r_miso, r_wr, r_wr_pend;
   state_t                              r_state;
   logic                                w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
   logic [REG_DATA_W-1:0]               w_rx_next;
   logic [REG_ADDR_W-1:0]               w_addr_inc, w_cmd_addr;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sclk (
      .i_clk(clk_clk), .i_rst_n(reset_reset_n), .i_d(spi_SCLK), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
   spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_ss (
      .i_clk(clk_clk), .i_rst_n(reset_reset_n), .i_d(spi_SS_n), .o_rise(w_ss_rise), .o_fall(w_ss_fall));

   assign w_rx_next  = {r_rx[REG_DATA_W-2:0], r_mosi_sync[SYNC_STAGES-1]};
   assign w_cmd_addr = w_rx_next[CMD_ADDR_MSB:CMD_ADDR_LSB];
   assign w_addr_inc = AUTO_INC ? r_addr + 5'd1 : r_addr;

   always_ff @(posedge clk_clk or negedge reset_reset_n)
      if (!reset_reset_n) begin
         r_mosi_sync <= '0;
         r_state     <= IDLE;
         r_bit_cnt   <= '0;
         r_rx        <= '0;
         r_tx        <= '0;
         r_miso      <= 1'b0;
         r_addr      <= '0;
         r_wr        <= 1'b0;
         r_wr_pend   <= 1'b0;
      end else begin
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_MOSI};
         r_wr_pend   <= 1'b0;
         if (r_wr_pend) r_addr <= w_addr_inc;
         if (w_ss_rise) begin
            r_state <= IDLE;
            r_miso  <= 1'b0;
         end else if (r_state == IDLE) begin
            if (w_ss_fall) begin
               r_state   <= CMD;
               r_bit_cnt <= '0;
               r_miso    <= r_regs[STATUS_ADDR][7];
               r_tx      <= {r_regs[STATUS_ADDR][6:0], 1'b0};
            end
         end else begin
            // r_tx holds the bits still to go; a full reload at byte end puts the next MSB out on the following fall
            if (w_sclk_fall) begin
               r_miso <= r_tx[7];
               r_tx   <= {r_tx[6:0], 1'b0};
            end
            if (w_sclk_rise) begin
               r_rx      <= w_rx_next;
               r_bit_cnt <= r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) begin
                  if (r_state == CMD) begin
                     r_state <= DATA;
                     r_addr  <= w_cmd_addr;
                     r_wr    <= w_rx_next[CMD_WR_BIT];
                     r_tx    <= w_rx_next[CMD_WR_BIT] ? r_regs[STATUS_ADDR] : r_regs[w_cmd_addr];
                  end else if (r_wr) begin
                     r_wr_pend <= 1'b1;
                     r_tx      <= r_regs[STATUS_ADDR];
                  end else begin
                     r_addr <= w_addr_inc;
                     r_tx   <= r_regs[w_addr_inc];
                  end
               end
            end
         end
      end

   // SPI write is issued last so it wins a same-address collision with the local port
   always_ff @(posedge clk_clk or negedge reset_reset_n)
      if (!reset_reset_n) begin
         r_regs  <= '0;
         r_rdata <= '0;
      end else begin
         if (reg_wr) r_regs[reg_addr] <= reg_wdata;
         if (r_wr_pend) r_regs[r_addr] <= r_rx;
         r_rdata <= r_regs[reg_addr];
      end

`ifdef SPI_REG_IRQ_EN
   logic r_irq;
   always_ff @(posedge clk_clk or negedge reset_reset_n)
      if (!reset_reset_n) r_irq <= 1'b0;
      else r_irq <= r_wr_pend | (r_irq & ~irq_ack);
   assign irq = r_irq;
`endif

   assign spi_MISO  = r_miso;
   assign reg_rdata = r_rdata;
   assign busy      = (r_state != IDLE);
endmodule
